// File: rtl/sbox_ram_param.sv
// RC4 S-box state memory: DEPTH x DW array, two async read ports, identity initialiser,
// atomic swap engine and a general write port. Optional macro: SBOX_FAST_INIT_EN (single-cycle init).
module sbox_ram_param #(
    parameter int DW = 8,
    parameter int AW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          init_start,
    output logic          init_busy,
    output logic          init_done,
    input  logic [AW-1:0] raddr_a,
    output logic [DW-1:0] rdata_a,
    input  logic [AW-1:0] raddr_b,
    output logic [DW-1:0] rdata_b,
    input  logic          wen,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    output logic          wr_err,
    input  logic          swap_valid,
    output logic          swap_ready,
    input  logic [AW-1:0] swap_addr_i,
    input  logic [AW-1:0] swap_addr_j,
    output logic          swap_done
);

    localparam int DEPTH = 2 ** AW;

    typedef enum logic [1:0] {ST_INIT, ST_IDLE, ST_SWAP} state_t;

    state_t        state_q, state_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          init_done_q, init_done_d;
    logic          wr_err_q, wr_err_d;
    logic          swap_done_q, swap_done_d;
    logic [AW-1:0] si_q, si_d, sj_q, sj_d;
    logic [DW-1:0] vi_q, vi_d, vj_q, vj_d;
    logic          swap_hs;

    logic [DW-1:0] mem [DEPTH];

    assign rdata_a = mem[raddr_a];
    assign rdata_b = mem[raddr_b];

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_INIT;
            cnt_q       <= '0;
            init_done_q <= 1'b0;
            wr_err_q    <= 1'b0;
            swap_done_q <= 1'b0;
            si_q        <= '0;
            sj_q        <= '0;
            vi_q        <= '0;
            vj_q        <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            init_done_q <= init_done_d;
            wr_err_q    <= wr_err_d;
            swap_done_q <= swap_done_d;
            si_q        <= si_d;
            sj_q        <= sj_d;
            vi_q        <= vi_d;
            vj_q        <= vj_d;
        end
    end

    // Handshake is suppressed by init_start, which has priority in IDLE
    assign swap_hs = swap_valid && swap_ready && !init_start;

    // Next-state logic
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        init_done_d = init_done_q;
        wr_err_d    = wen && (state_q != ST_IDLE);
        swap_done_d = 1'b0;
        si_d        = si_q;
        sj_d        = sj_q;
        vi_d        = vi_q;
        vj_d        = vj_q;
        unique case (state_q)
            ST_INIT: begin
`ifdef SBOX_FAST_INIT_EN
                cnt_d       = '0;
                state_d     = ST_IDLE;
                init_done_d = 1'b1;
`else
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == (AW+1)'(DEPTH - 1)) begin
                    state_d     = ST_IDLE;
                    init_done_d = 1'b1;
                end
`endif
            end
            ST_IDLE: begin
                if (init_start) begin
                    state_d     = ST_INIT;
                    cnt_d       = '0;
                    init_done_d = 1'b0;
                end else if (swap_hs) begin
                    state_d = ST_SWAP;
                    si_d    = swap_addr_i;
                    sj_d    = swap_addr_j;
                    vi_d    = mem[swap_addr_i];
                    vj_d    = mem[swap_addr_j];
                end
            end
            ST_SWAP: begin
                state_d     = ST_IDLE;
                swap_done_d = 1'b1;
            end
            default: state_d = ST_INIT;
        endcase
    end

    // Output logic
    always_comb begin
        init_busy  = (state_q == ST_INIT);
        swap_ready = (state_q == ST_IDLE) && !wen;
        init_done  = init_done_q;
        wr_err     = wr_err_q;
        swap_done  = swap_done_q;
    end

    // Array writes are held off during reset so an interrupted swap never commits
    always_ff @(posedge clk) begin
        if (rst_n) begin
            unique case (state_q)
                ST_INIT: begin
`ifdef SBOX_FAST_INIT_EN
                    for (int unsigned k = 0; k < DEPTH; k++) begin
                        mem[AW'(k)] <= DW'(k);
                    end
`else
                    mem[cnt_q[AW-1:0]] <= DW'(cnt_q[AW-1:0]);
`endif
                end
                ST_IDLE: begin
                    if (!init_start && wen) begin
                        mem[waddr] <= wdata;
                    end
                end
                ST_SWAP: begin
                    mem[si_q] <= vj_q;
                    mem[sj_q] <= vi_q;
                end
                default: ;
            endcase
        end
    end

endmodule
